sprite_loader: RTL and testbench

- Upstream feeder for the sprite bitmap shift register.
- Accepts a serial bitstream from a bit source over a valid/ready handshake. During vertical blanking it drives the register's shift, load and data inputs so one complete WIDTH*HEIGHT-bit bitmap replaces the current sprite.
- Outside a load it passes the display's shift requests through, so the register still rotates.
- Guarantees frame alignment: a bitmap is committed only as a full, uninterrupted load.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_loader.sv | 117 +++++++++++
 tb/tb_sprite_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite bitmap loader.
//   DEF_WIDTH / DEF_HEIGHT : default sprite size in pixels
//   NBITS                  : bits per bitmap at the default size
//   loader_state_e         : loader FSM states
package sprite_pkg;

  localparam int unsigned DEF_WIDTH  = 12;
  localparam int unsigned DEF_HEIGHT = 12;
  localparam int unsigned NBITS      = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/sprite_loader.sv
// Upstream feeder for the sprite bitmap shift register.
// Takes a serial bitmap over a valid/ready handshake and, during vertical
// blanking, replaces the whole sprite in one uninterrupted WIDTH*HEIGHT-bit
// load. Outside a load the display's shift requests pass straight through.
//   gclk, rst_ni   : clock, asynchronous active-low reset
//   vblank_i       : vertical blanking active
//   disp_shift_i   : display requests one sprite register shift
//   req_i          : upstream holds a new bitmap
//   bit_i          : bitmap bit, pixel 0 first
//   bit_valid_i    : bit_i valid
//   bit_ready_o    : bit_i accepted this cycle
//   shiftf_o       : shift enable to sprite register
//   load_o         : select data_o instead of rotate
//   data_o         : bit shifted into sprite register MSB
//   busy_o         : armed or loading
//   done_o         : one-cycle pulse on load completion
//   err_o          : sticky, last load aborted by end of vblank
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic gclk,
  input  logic rst_ni,
  input  logic vblank_i,
  input  logic disp_shift_i,
  input  logic req_i,
  input  logic bit_i,
  input  logic bit_valid_i,
  output logic bit_ready_o,
  output logic shiftf_o,
  output logic load_o,
  output logic data_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam int unsigned LNBITS = WIDTH * HEIGHT;
  localparam int unsigned CW     = $clog2(LNBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(LNBITS - 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          vblank_q;
  logic          err_q, err_d;

  logic vb_rise;
  logic accept;

  assign vb_rise = vblank_i & ~vblank_q;

  // The display always wins a collision; upstream holds the bit.
  assign bit_ready_o = (state_q == LOAD) & vblank_i & ~disp_shift_i;
  assign accept      = bit_valid_i & bit_ready_o;
  assign load_o      = accept;
  assign data_o      = bit_i & accept;
  assign shiftf_o    = disp_shift_i | accept;
  assign busy_o      = (state_q == ARMED) | (state_q == LOAD);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = ARMED;
      end
      ARMED: begin
        if (!req_i) begin
          state_d = IDLE;
        end else if (vb_rise) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        // accept implies vblank_i, so abort and completion are exclusive.
        if (!vblank_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
          count_d = '0;
        end else if (accept) begin
          if (count_q == LAST) begin
            state_d = DONE;
            count_d = '0;
            err_d   = 1'b0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      vblank_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      vblank_q <= vblank_i;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: a queue scoreboard holds the bitmap
// bits expected on data_o, and a model of the sprite register follows the
// shiftf_o/load_o/data_o outputs.
module tb_sprite_loader;

  localparam int NB = 144;

  logic gclk = 1'b0;
  logic rst_ni, vblank_i, disp_shift_i, req_i, bit_i, bit_valid_i;
  logic bit_ready_o, shiftf_o, load_o, data_o, busy_o, done_o, err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  int n_done   = 0;

  logic [NB-1:0] pat;
  logic [NB-1:0] spr = '0;
  logic          sb[$];

  always #5 gclk = ~gclk;

  sprite_loader #(.WIDTH(12), .HEIGHT(12)) dut (
    .gclk(gclk), .rst_ni(rst_ni), .vblank_i(vblank_i),
    .disp_shift_i(disp_shift_i), .req_i(req_i), .bit_i(bit_i),
    .bit_valid_i(bit_valid_i), .bit_ready_o(bit_ready_o),
    .shiftf_o(shiftf_o), .load_o(load_o), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Output monitor: sampled mid-cycle, away from the active edge.
  always @(negedge gclk) begin
    if (rst_ni) begin
      if (load_o) begin
        n_loads++;
        chk("sb_nonempty", NB'(sb.size() != 0), NB'(1));
        if (sb.size() != 0) chk("data_o", NB'(data_o), NB'(sb.pop_front()));
      end
      if (shiftf_o) spr = load_o ? {data_o, spr[NB-1:1]} : {spr[0], spr[NB-1:1]};
      if (done_o) n_done++;
    end
  end

  task automatic push_pattern();
    for (int i = 0; i < NB; i++) sb.push_back(pat[i]);
  endtask

  // Streams bits from index 0 until stop_at accepts. disp_shift_i is
  // forced for three cycles once index collide_at is reached.
  task automatic stream(input int stop_at, input int collide_at);
    int idx = 0;
    int cyc = 0;
    int coll = 0;
    logic acc;
    while (idx < stop_at && cyc < 2000) begin
      bit_valid_i  = 1'b1;
      bit_i        = pat[idx];
      disp_shift_i = (idx == collide_at) && (coll < 3);
      @(negedge gclk);
      if (disp_shift_i) begin
        chk("coll_ready", NB'(bit_ready_o), NB'(0));
        chk("coll_load",  NB'(load_o),      NB'(0));
        chk("coll_shift", NB'(shiftf_o),    NB'(1));
        coll++;
      end
      acc = bit_ready_o;
      step();
      if (acc) idx++;
      cyc++;
    end
    bit_valid_i  = 1'b0;
    disp_shift_i = 1'b0;
    chk("stream_accepts", NB'(idx), NB'(stop_at));
  endtask

  task automatic arm_and_rise();
    req_i    = 1'b1;
    vblank_i = 1'b0;
    step();
    step();
    chk("armed_busy", NB'(busy_o), NB'(1));
    vblank_i = 1'b1;
  endtask

  task automatic finish_load(input string tag, input int l0, input int d0);
    chk({tag, "_done"}, NB'(done_o), NB'(1));
    chk({tag, "_err"},  NB'(err_o),  NB'(0));
    req_i = 1'b0;
    step();
    chk({tag, "_done_low"}, NB'(done_o), NB'(0));
    chk({tag, "_idle"},     NB'(busy_o), NB'(0));
    chk({tag, "_nloads"},   NB'(n_loads - l0), NB'(NB));
    chk({tag, "_ndone"},    NB'(n_done - d0),  NB'(1));
    chk({tag, "_sb_empty"}, NB'(sb.size()),    NB'(0));
    vblank_i = 1'b0;
    step();
  endtask

  initial begin
    int l0, d0;
    rst_ni = 1'b0; vblank_i = 1'b0; disp_shift_i = 1'b0;
    req_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
    for (int i = 0; i < NB; i += 32) pat[i +: 32] = $urandom;
    #1;
    chk("rst_ready", NB'(bit_ready_o), NB'(0));
    chk("rst_shift", NB'(shiftf_o),    NB'(0));
    chk("rst_load",  NB'(load_o),      NB'(0));
    chk("rst_busy",  NB'(busy_o),      NB'(0));
    chk("rst_done",  NB'(done_o),      NB'(0));
    chk("rst_err",   NB'(err_o),       NB'(0));
    step(); step();
    @(negedge gclk) rst_ni = 1'b1;
    step();
    chk("post_rst_busy", NB'(busy_o), NB'(0));

    // Full load
    l0 = n_loads; d0 = n_done;
    push_pattern();
    arm_and_rise();
    stream(NB, -1);
    chk("full_sprite", spr, pat);
    finish_load("full", l0, d0);

    // Collision during load
    for (int i = 0; i < NB; i += 32) pat[i +: 32] = $urandom;
    l0 = n_loads; d0 = n_done;
    push_pattern();
    arm_and_rise();
    stream(NB, 60);
    finish_load("coll", l0, d0);

    // Abort after 100 accepts, then a clean reload
    l0 = n_loads; d0 = n_done;
    push_pattern();
    arm_and_rise();
    stream(100, -1);
    vblank_i = 1'b0;
    req_i    = 1'b0;
    step();
    chk("abort_err",    NB'(err_o),  NB'(1));
    chk("abort_idle",   NB'(busy_o), NB'(0));
    chk("abort_nloads", NB'(n_loads - l0), NB'(100));
    step();
    chk("abort_ndone",  NB'(n_done - d0), NB'(0));
    sb.delete();
    l0 = n_loads; d0 = n_done;
    push_pattern();
    arm_and_rise();
    stream(NB, -1);
    chk("reload_sprite", spr, pat);
    finish_load("reload", l0, d0);

    // Request while vblank already high
    vblank_i = 1'b1;
    step(); step();
    req_i       = 1'b1;
    bit_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge gclk);
      chk("midvb_ready", NB'(bit_ready_o), NB'(0));
      step();
    end
    chk("midvb_busy", NB'(busy_o), NB'(1));
    bit_valid_i = 1'b0;
    vblank_i    = 1'b0;
    step();
    vblank_i = 1'b1;
    step();
    @(negedge gclk);
    chk("midvb_ready_after_rise", NB'(bit_ready_o), NB'(1));
    step();
    vblank_i = 1'b0;
    req_i    = 1'b0;
    step();
    chk("midvb_abort_err", NB'(err_o), NB'(1));

    // Passthrough in IDLE
    bit_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      disp_shift_i = i[0];
      @(negedge gclk);
      chk("pass_shift", NB'(shiftf_o),    NB'(i[0]));
      chk("pass_load",  NB'(load_o),      NB'(0));
      chk("pass_ready", NB'(bit_ready_o), NB'(0));
      step();
    end
    disp_shift_i = 1'b0;
    bit_valid_i  = 1'b0;

    // Asynchronous reset at accept 50
    push_pattern();
    arm_and_rise();
    stream(50, -1);
    bit_valid_i = 1'b1;
    bit_i       = 1'b1;
    #1;
    chk("pre_rst_ready", NB'(bit_ready_o), NB'(1));
    chk("pre_rst_err",   NB'(err_o),       NB'(1));
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_ready", NB'(bit_ready_o), NB'(0));
    chk("arst_shift", NB'(shiftf_o),    NB'(0));
    chk("arst_load",  NB'(load_o),      NB'(0));
    chk("arst_data",  NB'(data_o),      NB'(0));
    chk("arst_busy",  NB'(busy_o),      NB'(0));
    chk("arst_done",  NB'(done_o),      NB'(0));
    chk("arst_err",   NB'(err_o),       NB'(0));
    bit_valid_i = 1'b0;
    req_i       = 1'b0;
    vblank_i    = 1'b0;
    sb.delete();
    step();
    @(negedge gclk) rst_ni = 1'b1;
    step();
    chk("rel_busy", NB'(busy_o), NB'(0));
    chk("rel_err",  NB'(err_o),  NB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
